pong_frame_compositor: RTL

//  Pipelined, parametrised pixel compositor for the Pong VGA path. It sits between the VGA timing

---
 rtl/pong_frame_compositor_pkg.sv | 33 +++
 rtl/pong_frame_compositor_if.sv | 32 +++
 rtl/pong_frame_compositor_glyph.sv | 27 ++
 rtl/pong_frame_compositor.sv | 123 ++++++++++++
 4 files changed

// File: rtl/pong_frame_compositor_pkg.sv
// Shared types and constants for the Pong frame compositor: colours, cell widths,
// flash state encoding, the per-frame shadow record and a span hit helper.
package pong_pkg;
   localparam int X_W = 8;
   localparam int Y_W = 7;

   localparam logic [7:0] FG_COLOR_D    = 8'hFF;
   localparam logic [7:0] DIGIT_COLOR_D = 8'hE0;
   localparam logic [7:0] BG_COLOR_D    = 8'h00;
   localparam logic [7:0] FLASH_COLOR_D = 8'h03;

   typedef enum logic {
      FLASH_IDLE = 1'b0,
      FLASH_ON   = 1'b1
   } flash_state_e;

   typedef struct packed {
      logic [X_W-1:0] ball_x;
      logic [Y_W-1:0] ball_y;
      logic [X_W-1:0] player_x;
      logic [Y_W-1:0] player_y;
      logic [X_W-1:0] com_x;
      logic [Y_W-1:0] com_y;
      logic [3:0]     player_score;
      logic [3:0]     com_score;
   } shadow_t;

   // One-axis containment o <= c < o+len, widened to 9 bits so o+len never wraps.
   function automatic logic span_hit(input logic [7:0] c, input logic [7:0] o,
                                     input logic [8:0] len);
      return ({1'b0, c} >= {1'b0, o}) && ({1'b0, c} < ({1'b0, o} + len));
   endfunction
endpackage

// File: rtl/pong_frame_compositor_if.sv
// Pixel/scene bus between the VGA timing side and the compositor.
interface pong_frame_compositor_if;
   import pong_pkg::*;

   logic           pix_valid;
   logic [9:0]     xCoord;
   logic [9:0]     yCoord;
   logic           frame_start;
   logic [X_W-1:0] ballX;
   logic [Y_W-1:0] ballY;
   logic [X_W-1:0] playerXPos;
   logic [Y_W-1:0] playerYPos;
   logic [X_W-1:0] comXPos;
   logic [Y_W-1:0] comYPos;
   logic [3:0]     playerScore;
   logic [3:0]     comScore;
   logic           goal_pulse;
   logic [7:0]     RGB_out;
   logic           RGB_valid;

   modport master (
      output pix_valid, xCoord, yCoord, frame_start, ballX, ballY, playerXPos, playerYPos,
             comXPos, comYPos, playerScore, comScore, goal_pulse,
      input  RGB_out, RGB_valid
   );

   modport slave (
      input  pix_valid, xCoord, yCoord, frame_start, ballX, ballY, playerXPos, playerYPos,
             comXPos, comYPos, playerScore, comScore, goal_pulse,
      output RGB_out, RGB_valid
   );
endinterface

// File: rtl/pong_frame_compositor_glyph.sv
// 3x5 score digit font; index 0 is the top-left cell, row-major. Digits 10-15 are blank.
module digit_glyph_rom (
   input  logic [3:0] digit,
   input  logic [3:0] index,
   output logic       pixel
);
   logic [14:0] glyph;

   always_comb begin
      glyph = '0;
      case (digit)
         4'd0: glyph = 15'b111_101_101_101_111;
         4'd1: glyph = 15'b010_110_010_010_111;
         4'd2: glyph = 15'b111_001_111_100_111;
         4'd3: glyph = 15'b111_001_111_001_111;
         4'd4: glyph = 15'b101_101_111_001_001;
         4'd5: glyph = 15'b111_100_111_001_111;
         4'd6: glyph = 15'b111_100_111_101_111;
         4'd7: glyph = 15'b111_001_001_001_001;
         4'd8: glyph = 15'b111_101_111_101_111;
         4'd9: glyph = 15'b111_101_111_001_111;
         default: glyph = '0;
      endcase
      pixel = 1'b0;
      if (index <= 4'd14) pixel = glyph[4'd14 - index];
   end
endmodule

// File: rtl/pong_frame_compositor.sv
// Two-stage pixel compositor: S1 scales the pixel to cells, S2 hit-tests the frame-latched
// scene and applies layer priority. Goal events flash the background for FLASH_FRAMES frames.
module pong_frame_compositor
   import pong_pkg::*;
#(
   parameter int         SCALE_SHIFT  = 2,
   parameter int         BALL_SIZE    = 4,
   parameter int         PADDLE_W     = 2,
   parameter int         PADDLE_LEN   = 32,
   parameter int         NET_EN       = 1,
   parameter int         NET_X        = 80,
   parameter int         DIGIT_Y      = 10,
   parameter int         DIGIT0_X     = 60,
   parameter int         DIGIT1_X     = 97,
   parameter int         FLASH_FRAMES = 8,
   parameter logic [7:0] FG_COLOR     = FG_COLOR_D,
   parameter logic [7:0] DIGIT_COLOR  = DIGIT_COLOR_D,
   parameter logic [7:0] BG_COLOR     = BG_COLOR_D,
   parameter logic [7:0] FLASH_COLOR  = FLASH_COLOR_D
) (
   input  logic                    CLK_IN,
   input  logic                    RESET_IN,
   pong_frame_compositor_if.slave  bus
);
   shadow_t      sh_d, sh_q;
   flash_state_e fstate_d, fstate_q;
   logic [7:0]   fcnt_d, fcnt_q;
   logic [7:0]   x1_p1_d, x1_p1_q, y1_p1_d, y1_p1_q;
   logic         vld_p1_d, vld_p1_q;
   logic [7:0]   rgb_p2_d, rgb_p2_q;
   logic         vld_p2_d, vld_p2_q;

   logic [7:0]   bg, dy, dx0, dx1;
   logic [3:0]   idx0, idx1;
   logic         g0, g1, in_d0, in_d1, in_ball, in_player, in_com, in_net;

   always_comb begin
      sh_d = sh_q;
      if (bus.frame_start) begin
         sh_d = '{ball_x: bus.ballX, ball_y: bus.ballY,
                  player_x: bus.playerXPos, player_y: bus.playerYPos,
                  com_x: bus.comXPos, com_y: bus.comYPos,
                  player_score: bus.playerScore, com_score: bus.comScore};
      end
   end

   // A goal reload takes precedence over a same-cycle frame decrement.
   always_comb begin
      fstate_d = fstate_q;
      fcnt_d   = fcnt_q;
      if (bus.goal_pulse) begin
         fstate_d = FLASH_ON;
         fcnt_d   = 8'(FLASH_FRAMES);
      end else if (fstate_q == FLASH_ON && bus.frame_start) begin
         fcnt_d = fcnt_q - 8'd1;
         if (fcnt_q == 8'd1) fstate_d = FLASH_IDLE;
      end
   end

   // Stage 1: pixel -> cell coordinates
   always_comb begin
      x1_p1_d  = 8'(bus.xCoord >> SCALE_SHIFT);
      y1_p1_d  = 8'(bus.yCoord >> SCALE_SHIFT);
      vld_p1_d = bus.pix_valid;
   end

   // Stage 2: hit tests against the shadows and layer priority
   always_comb begin
      bg   = (fstate_q == FLASH_ON && fcnt_q[0]) ? FLASH_COLOR : BG_COLOR;
      dy   = y1_p1_q - 8'(DIGIT_Y);
      dx0  = x1_p1_q - 8'(DIGIT0_X);
      dx1  = x1_p1_q - 8'(DIGIT1_X);
      idx0 = 4'((dy * 8'd3) + dx0);
      idx1 = 4'((dy * 8'd3) + dx1);

      in_d0     = span_hit(x1_p1_q, 8'(DIGIT0_X), 9'd3) && span_hit(y1_p1_q, 8'(DIGIT_Y), 9'd5);
      in_d1     = span_hit(x1_p1_q, 8'(DIGIT1_X), 9'd3) && span_hit(y1_p1_q, 8'(DIGIT_Y), 9'd5);
      in_ball   = span_hit(x1_p1_q, sh_q.ball_x, 9'(BALL_SIZE))
               && span_hit(y1_p1_q, {1'b0, sh_q.ball_y}, 9'(BALL_SIZE));
      in_player = span_hit(x1_p1_q, sh_q.player_x, 9'(PADDLE_W))
               && span_hit(y1_p1_q, {1'b0, sh_q.player_y}, 9'(PADDLE_LEN));
      in_com    = span_hit(x1_p1_q, sh_q.com_x, 9'(PADDLE_W))
               && span_hit(y1_p1_q, {1'b0, sh_q.com_y}, 9'(PADDLE_LEN));
      in_net    = (NET_EN != 0) && (x1_p1_q == 8'(NET_X)) && !y1_p1_q[2];

      rgb_p2_d = 8'h00;
      if (vld_p1_q) begin
         if (in_d0)                                  rgb_p2_d = g0 ? DIGIT_COLOR : bg;
         else if (in_d1)                             rgb_p2_d = g1 ? DIGIT_COLOR : bg;
         else if (in_ball || in_player || in_com || in_net) rgb_p2_d = FG_COLOR;
         else                                        rgb_p2_d = bg;
      end
      vld_p2_d = vld_p1_q;
   end

   digit_glyph_rom u_glyph0 (.digit(sh_q.player_score), .index(idx0), .pixel(g0));
   digit_glyph_rom u_glyph1 (.digit(sh_q.com_score),    .index(idx1), .pixel(g1));

   always_ff @(posedge CLK_IN) begin
      if (RESET_IN) begin
         sh_q     <= '0;
         fstate_q <= FLASH_IDLE;
         fcnt_q   <= '0;
         x1_p1_q  <= '0;
         y1_p1_q  <= '0;
         vld_p1_q <= 1'b0;
         rgb_p2_q <= '0;
         vld_p2_q <= 1'b0;
      end else begin
         sh_q     <= sh_d;
         fstate_q <= fstate_d;
         fcnt_q   <= fcnt_d;
         x1_p1_q  <= x1_p1_d;
         y1_p1_q  <= y1_p1_d;
         vld_p1_q <= vld_p1_d;
         rgb_p2_q <= rgb_p2_d;
         vld_p2_q <= vld_p2_d;
      end
   end

   assign bus.RGB_out   = rgb_p2_q;
   assign bus.RGB_valid = vld_p2_q;
endmodule
